// File: rtl/i2s_buffer_sequencer.sv
// Record/playback sequencer for an I2S sample buffer: arms on a start edge, records DEPTH
// samples from the frame boundary, waits for the RAM to report the buffer, then plays it back.
module i2s_buffer_sequencer #(
  parameter int DEPTH   = 1024,
  parameter int TIMEOUT = 4096,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int TO_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             frame_start_i,
  input  logic             sample_ready_i,
  input  logic             wr_ready_i,
  output logic             wr_valid_o,
  input  logic             buffer_ready_i,
  input  logic             rd_valid_i,
  input  logic             tx_ready_i,
  output logic             rd_ready_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] wr_count_o,
  output logic [CNT_W-1:0] rd_count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  output logic             timeout_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    RECORD   = 3'd2,
    WAIT_BUF = 3'd3,
    PLAY     = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  // Edge detection is held off until the synchronizer and history flop carry real
  // samples, so a start_i already high at reset release never looks like a rising edge.
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;
  logic [2:0] vld_pipe_q, vld_pipe_d;
  logic       start_pulse;

  always_comb begin
    sync_d     = {sync_q[0], start_i};
    prev_d     = sync_q[1];
    vld_pipe_d = {vld_pipe_q[1:0], 1'b1};
  end

  assign start_pulse = sync_q[1] & ~prev_q & vld_pipe_q[2];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic             ovr_q, ovr_d, to_q, to_d, done_q, done_d, busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    timer_d  = timer_q;
    ovr_d    = ovr_q;
    to_d     = to_q;
    done_d   = 1'b0;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start_pulse) begin
          state_d  = ARM;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          ovr_d    = 1'b0;
          to_d     = 1'b0;
        end
        ARM: if (frame_start_i) state_d = RECORD;
        RECORD: begin
          if (sample_ready_i && !wr_ready_i) ovr_d = 1'b1;
          if (sample_ready_i && wr_ready_i && wr_cnt_q != DEPTH_C) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
            if (wr_cnt_q == LAST_C) begin
              state_d = WAIT_BUF;
              timer_d = '0;
            end
          end
        end
        WAIT_BUF: begin
          if (buffer_ready_i) begin
            state_d = PLAY;
          end else if (timer_q == TO_LAST) begin
            state_d = IDLE;
            to_d    = 1'b1;
          end else begin
            timer_d = timer_q + TO_W'(1);
          end
        end
        PLAY: if (rd_valid_i && tx_ready_i && rd_cnt_q != DEPTH_C) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == LAST_C) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      vld_pipe_q <= '0;
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      timer_q    <= '0;
      ovr_q      <= 1'b0;
      to_q       <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      vld_pipe_q <= vld_pipe_d;
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      timer_q    <= timer_d;
      ovr_q      <= ovr_d;
      to_q       <= to_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_valid_o = (state_q == RECORD) & sample_ready_i;
  assign rd_ready_o = (state_q == PLAY) & tx_ready_i;
  assign state_o    = state_q;
  assign wr_count_o = wr_cnt_q;
  assign rd_count_o = rd_cnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overrun_o  = ovr_q;
  assign timeout_o  = to_q;

endmodule
